// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// It takes its operands from the register-file read ports and runs a
// fixed 32-step sequence: shift-add for multiplies, restoring division
// for divides. When it finishes, it drives the register-file write port
// for exactly one cycle. The core stalls while busy is high.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             request, sampled only in IDLE
//   op[2:0]           funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                             4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_data[31:0]    operand A / dividend
//   rs2_data[31:0]    operand B / divisor
//   rd_addr_in[4:0]   destination register, captured with start
//   busy              high from the accepting edge through the done cycle
//   done              one-cycle completion pulse
//   rd_wren           done && (rd_addr != 0)
//   rd_addr[4:0]      captured destination (driven only while done)
//   rd_data[31:0]     result (zero except while done)
//
// Configuration:
//   MULDIV_DIV_EN     When defined, the divider datapath is built and the
//                     unit implements full RV32M. When undefined, ops 4-7
//                     are still accepted. They go straight from IDLE to
//                     DONE and return 0.

module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr_in,
  output logic        busy,
  output logic        done,
  output logic        rd_wren,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  // Held operand: the multiplicand for MUL*, the divisor for DIV*/REM*.
  logic [31:0] opnd_q, opnd_d;
  // MUL*: full 64-bit product. The multiplier starts in [31:0] and shifts out.
  // DIV*: [31:0] starts as the dividend and becomes the quotient.
  logic [63:0] acc_q, acc_d;
  // Result must be negated: product sign for MUL*, quotient sign for DIV*.
  logic        negQ_q, negQ_d;

  logic        signed1, signed2;
  logic [31:0] rs1Mag, rs2Mag;
  logic [32:0] mulSum;
  logic [63:0] prodFinal;
  logic [31:0] result;

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_q, rem_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;
  logic        ovf_q, ovf_d;
  logic [32:0] divShift;
  logic [33:0] divDiff;
  logic [31:0] quot, remd;
`endif

  // Operand conditioning. Only the signed ops take magnitudes.
  // MUL is treated as unsigned because its low word does not depend on signedness.
  always_comb begin
    signed1 = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    signed2 = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    rs1Mag  = (signed1 && rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
    rs2Mag  = (signed2 && rs2_data[31]) ? (32'd0 - rs2_data) : rs2_data;
  end

  // One iteration of each datapath, computed from the current registers.
  // mulSum keeps the carry out of the upper word.
  // divDiff has a spare bit so its MSB acts as the borrow flag.
  always_comb begin
    mulSum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
`ifdef MULDIV_DIV_EN
    divShift = {rem_q[31:0], acc_q[31]};
    divDiff  = {1'b0, divShift} - {2'b00, opnd_q};
`endif
  end

  // Next-state and datapath update.
  // Captures the request in IDLE, runs one step per CALC cycle, and returns to IDLE after DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    negQ_d  = negQ_q;
`ifdef MULDIV_DIV_EN
    rem_d     = rem_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          rd_d   = rd_addr_in;
          cnt_d  = 5'd0;
          negQ_d = (signed1 && rs1_data[31]) ^ (signed2 && rs2_data[31]);
          if (op[2]) begin
            opnd_d = rs2Mag;
            acc_d  = {32'd0, rs1Mag};
          end else begin
            opnd_d = rs1Mag;
            acc_d  = {32'd0, rs2Mag};
          end
`ifdef MULDIV_DIV_EN
          rem_d     = 33'd0;
          negRem_d  = signed1 && rs1_data[31];
          divZero_d = (rs2_data == 32'd0);
          ovf_d     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
          state_d   = CALC;
`else
          state_d   = op[2] ? DONE : CALC;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
        if (op_q[2]) begin
          if (!divDiff[33]) begin
            rem_d       = divDiff[32:0];
            acc_d[31:0] = {acc_q[30:0], 1'b1};
          end else begin
            rem_d       = divShift;
            acc_d[31:0] = {acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mulSum, acc_q[31:1]};
        end
`else
        acc_d = {mulSum, acc_q[31:1]};
`endif
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result selection in DONE, including sign fix-up and the divide special cases.
  always_comb begin
    prodFinal = negQ_q ? (64'd0 - acc_q) : acc_q;
    result    = (op_q == OP_MUL) ? prodFinal[31:0] : prodFinal[63:32];
`ifdef MULDIV_DIV_EN
    quot = negQ_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    remd = negRem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    if (op_q[2]) begin
      if (op_q[1]) begin
        // A zero divisor leaves the dividend magnitude in the remainder.
        // Re-applying the dividend sign therefore reproduces rs1 as captured.
        result = ovf_q ? 32'd0 : remd;
      end else if (divZero_q) begin
        result = 32'hFFFF_FFFF;
      end else if (ovf_q) begin
        result = 32'h8000_0000;
      end else begin
        result = quot;
      end
    end
`else
    if (op_q[2]) begin
      result = 32'd0;
    end
`endif
  end

  // Output decode. Address and data are forced to zero outside DONE.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    rd_addr = done ? rd_q : 5'd0;
    rd_wren = done && (rd_q != 5'd0);
    rd_data = done ? result : 32'd0;
  end

  // State and datapath registers. Reset clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      negQ_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q     <= 33'd0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      negQ_q  <= negQ_d;
`ifdef MULDIV_DIV_EN
      rem_q     <= rem_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
//
// The bench uses a table of directed vectors, a few hand-written handshake
// and reset sequences, and randomized operations. Results are checked
// against an arithmetic reference model. The model follows MULDIV_DIV_EN
// the same way the design does.

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1Data = 32'd0;
  logic [31:0] rs2Data = 32'd0;
  logic [4:0]  rdAddrIn = 5'd0;
  logic        busy, done, rdWren;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .rs1_data(rs1Data),
    .rs2_data(rs2Data),
    .rd_addr_in(rdAddrIn),
    .busy(busy),
    .done(done),
    .rd_wren(rdWren),
    .rd_addr(rdAddr),
    .rd_data(rdData)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] expData;
  } vec_t;

  vec_t vecTable[16];

  // Compares one value and records a miscompare with a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model written directly from RV32M arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      default: ;
    endcase
`ifdef MULDIV_DIV_EN
    case (o)
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
`else
    return 32'd0;
`endif
  endfunction

  // Issues one operation and checks latency, result, write port and pulse width.
  // mode 1 changes the operands right after acceptance.
  // mode 2 pulses start again in the middle of CALC.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expData,
                               input int mode);
    int cycles;
    int expLat;
`ifdef MULDIV_DIV_EN
    expLat = 32;
`else
    expLat = o[2] ? 0 : 32;
`endif
    @(negedge clk);
    op       = o;
    rs1Data  = a;
    rs2Data  = b;
    rdAddrIn = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (mode == 1) begin
      rs1Data = $urandom;
      rs2Data = $urandom;
      op      = 3'(~o);
    end
    checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (mode == 2) start = (cycles == 5);
    end
    start = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(expLat));
    checkOutput("rdData", rdData, expData);
    checkOutput("rdWren", 32'(rdWren), 32'(rd != 5'd0));
    checkOutput("rdAddr", 32'(rdAddr), 32'(rd));
    @(posedge clk);
    #1;
    checkOutput("doneFalls", 32'({done, busy}), 32'd0);
    if (mode == 2) begin
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (done) cycles++;
      end
      checkOutput("extraDone", 32'(cycles), 32'd0);
    end
  endtask

  // Fills the directed table. Divide entries carry the full RV32M results.
  // In a build without MULDIV_DIV_EN the apply loop expects 0 for them instead.
  task automatic fillTable();
    vecTable[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0001};
    vecTable[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
    vecTable[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
    vecTable[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
    vecTable[4]  = '{3'd0, 32'd6,         32'd7,         5'd5,  32'd42};
    vecTable[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000};
    vecTable[6]  = '{3'd0, 32'd3,         32'd5,         5'd0,  32'd15};
    vecTable[7]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD};
    vecTable[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF};
    vecTable[9]  = '{3'd5, 32'hFFFF_FFFE, 32'h10,        5'd9,  32'h0FFF_FFFF};
    vecTable[10] = '{3'd4, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF};
    vecTable[11] = '{3'd7, 32'd5,         32'd0,         5'd11, 32'd5};
    vecTable[12] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    vecTable[13] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0};
    vecTable[14] = '{3'd5, 32'd10,        32'd2,         5'd14, 32'd5};
    vecTable[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1};
  endtask

  // Main test sequence.
  initial begin
    logic [2:0]  rOp;
    logic [31:0] rA, rB, expData;
    logic [4:0]  rRd;
    int          doneCount;

    fillTable();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutputs", {busy, done, rdWren, rdAddr, rdData[24:0]}, 32'd0);
    checkOutput("resetData", rdData, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      expData = vecTable[i].expData;
`ifndef MULDIV_DIV_EN
      if (vecTable[i].op[2]) expData = 32'd0;
`endif
      applyStimulus(vecTable[i].op, vecTable[i].a, vecTable[i].b,
                    vecTable[i].rd, expData, 0);
    end

    // Operands changed after acceptance must not affect the result.
    applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20,
                  refModel(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 1);
    applyStimulus(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd21,
                  refModel(3'd4, 32'hFFFF_FF9C, 32'd7), 1);

    // A second start during CALC is ignored. Only one done pulse follows.
    applyStimulus(3'd0, 32'd1000, 32'd1000, 5'd22, 32'd1_000_000, 2);

    // Reset in the middle of CALC aborts the operation silently.
    @(negedge clk);
    op = 3'd0; rs1Data = 32'd3; rs2Data = 32'd5; rdAddrIn = 5'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetOutputs", {busy, done, rdWren, rdAddr, rdData[24:0]}, 32'd0);
    checkOutput("midResetData", rdData, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) doneCount++;
    end
    checkOutput("midResetNoDone", 32'(doneCount), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = $urandom;
      rB  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rB = 32'($urandom_range(1, 20));
      rRd = 5'($urandom_range(0, 31));
      applyStimulus(rOp, rA, rB, rRd, refModel(rOp, rA, rB), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the core. Takes operands straight from the register-file read ports (rs1_data/rs2_data), runs a fixed-latency 32-step shift-add or restoring-divide sequence, and drives the register-file write port (rd_wren/rd_addr/rd_data) for one cycle on completion. The core stalls on busy.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  32  operand A / dividend.
- rs2_data  in  32  operand B / divisor.
- rd_addr_in  in  5  destination register, captured with start.
- busy  out  1  high from the accepting edge through the done cycle.
- done  out  1  one-cycle completion pulse.
- rd_wren  out  1  done && (rd_addr != 0).
- rd_addr  out  5  captured destination.
- rd_data  out  32  result; valid only while done=1.

## Operation
- FSM: IDLE -> CALC -> DONE -> IDLE.
- IDLE: busy=0. On start=1, capture op, rd_addr_in, |rs1|, |rs2| (signed ops take the absolute value; unsigned ops take the raw value), and the result-sign flags. Counter cleared. Next state CALC.
- CALC: one iteration per edge, 5-bit counter, 32 iterations. After the 32nd, next state DONE.
- MUL*: unsigned shift-add into a 64-bit accumulator. If the operand signs differ, the product is negated (two's complement, 64-bit).
  - MUL returns [31:0].
  - MULH, MULHSU and MULHU return [63:32].
  - MULHSU treats only rs1 as signed.
- DIV*/REM*: restoring division on magnitudes with a 33-bit partial remainder.
  - The quotient is negated if the operand signs differ (signed ops only).
  - The remainder takes the dividend's sign.
- Special cases resolve in DONE; latency is unchanged.
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1 as captured.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- DONE: done=1, busy=1, rd_data/rd_addr driven; rd_wren as defined above. Next state IDLE unconditionally.
- start is ignored while busy=1; there is no queueing. start may be reasserted in the cycle after done falls.
- Operands are captured at acceptance. Later changes on rs1_data/rs2_data have no effect.

## Timing
- Reset: state IDLE. busy=0, done=0, rd_wren=0, rd_addr=0, rd_data=0; internal accumulators and counter cleared.
- start sampled at edge E0. busy=1 after E0. CALC iterations occur at E1..E32. DONE holds between E32 and E33; the regfile write lands at E33. busy=0 after E33.
- Total: 33 cycles from accept to write; back-to-back issue every 34 cycles.
- rst asserted mid-CALC or in DONE: return to IDLE at that edge, with no done pulse and no write.
- rd_data is 0 in all states except DONE.

## Configuration
- MULDIV_DIV_EN defined: full RV32M as described.
- MULDIV_DIV_EN undefined: divider datapath compiled out.
  - op 4-7 are still accepted, but go IDLE -> DONE directly.
  - done pulses in the cycle after E0, with rd_data=0 and rd_wren per the normal rule.
  - MUL ops are unaffected.

## Test plan
- Reset mid-op: start MUL 3*5 with rd=x5, assert rst at E10 -> no done pulse, busy=0, all outputs 0.
- MUL and MULH: MUL 0xFFFFFFFF*0xFFFFFFFF with rd=x1 -> rd_data=0x00000001 at E32-E33. MULH on the same operands -> 0x00000000. MULHU on the same operands -> 0xFFFFFFFE.
- Signed division: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/0x10 -> 0x0FFFFFFF.
- Divide-special cases: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Handshake: pulse start again during CALC -> ignored, exactly one done. rd=x0 -> done=1, rd_wren=0. Operands changed after E0 -> result unchanged.
- Build without MULDIV_DIV_EN: DIVU 10/2 -> done after 1 cycle with rd_data=0; MUL 6*7 -> 42 at normal latency.
